// File: rtl/pe_array_seq_ctrl_pkg.sv
// pe_array_seq_ctrl_pkg: shared sequencer state encoding and flush-length helper
package pe_array_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  // The wavefront must cross the array diagonally, then the MAC pipeline must empty
  function automatic int flush_len(input int dim, input int lat);
    return 2 * (dim - 1) + lat;
  endfunction

endpackage

// File: rtl/pe_array_seq_ctrl_down_counter.sv
// seq_down_counter: loadable down-counter with zero flag, shared by flush and drain
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load wins over decrement; decrement stops at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);

  assign zero = count == '0;

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// pe_array_seq_ctrl: tile sequencer for a systolic PE array (clear, feed, flush, drain)
module pe_array_seq_ctrl
  import pe_array_seq_ctrl_pkg::*;
#(
  parameter int ARRAY_DIM = 4,
  parameter int K_W       = 12,
  parameter int ADDR_W    = 10,
  parameter int MAC_LAT   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [K_W-1:0]               k_len,
  input  logic                         op_valid,
  input  logic                         out_ready,
  output logic                         op_rd,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic                         pe_en,
  output logic                         pe_clear,
  output logic                         zero_inj,
  output logic [$clog2(ARRAY_DIM)-1:0] drain_col,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int FLUSH_LEN = flush_len(ARRAY_DIM, MAC_LAT);
  localparam int CNT_MAX   = FLUSH_LEN > ARRAY_DIM ? FLUSH_LEN : ARRAY_DIM;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int COL_W     = $clog2(ARRAY_DIM);

  state_t             state, state_nx;
  logic [K_W-1:0]     k_q, feed_cnt;
  logic               flush_q;
  logic               pop, take;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_val, cnt;

  assign pop      = state == S_FEED && op_valid;
  assign take     = state == S_DRAIN && out_ready;
  assign cnt_load = (state_nx == S_FLUSH && state != S_FLUSH) || (state_nx == S_DRAIN && state != S_DRAIN);
  assign cnt_val  = state_nx == S_FLUSH ? CNT_W'(FLUSH_LEN - 1) : CNT_W'(ARRAY_DIM - 1);
  assign cnt_dec  = state == S_FLUSH || take;
  assign op_rd    = pop;
  assign pe_en    = state == S_FEED ? op_valid : flush_q;
  assign zero_inj = flush_q;

  // One counter times both flush length and drain beats since they never overlap
  seq_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = start ? S_CLEAR : S_IDLE;
      S_CLEAR: state_nx = k_q == '0 ? S_DRAIN : S_FEED;
      S_FEED:  state_nx = op_valid && feed_cnt == k_q - K_W'(1) ? S_FLUSH : S_FEED;
      S_FLUSH: state_nx = cnt_zero ? S_DRAIN : S_FLUSH;
      S_DRAIN: state_nx = out_ready && cnt_zero ? S_DONE : S_DRAIN;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;

  // Tile length latch, feed counter, read address and drain column
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      k_q       <= '0;
      feed_cnt  <= '0;
      rd_addr   <= '0;
      drain_col <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        k_q      <= k_len;
        feed_cnt <= '0;
        rd_addr  <= '0;
      end else if (pop) begin
        feed_cnt <= feed_cnt + K_W'(1);
        rd_addr  <= rd_addr + ADDR_W'(1);
      end
      drain_col <= state_nx != S_DRAIN ? '0 : take ? drain_col + COL_W'(1) : drain_col;
    end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pe_clear  <= 1'b1;
      flush_q   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pe_clear  <= state_nx == S_CLEAR;
      flush_q   <= state_nx == S_FLUSH;
      out_valid <= state_nx == S_DRAIN;
      busy      <= state_nx != S_IDLE;
      done      <= state_nx == S_DONE;
    end

endmodule
